// File: rtl/rx_arb_pkg.sv
// Shared constants, types and helpers for the receiver stream arbiter.
package rx_arb_pkg;

  localparam int unsigned RX_DATA_WIDTH = 24;
  localparam int unsigned RX_MAX_CH     = 8;
  localparam int unsigned RX_IDX_W      = $clog2(RX_MAX_CH);

  typedef logic [RX_IDX_W-1:0] rx_idx_t;

  typedef struct packed {
    rx_idx_t                  chan;
    logic [RX_DATA_WIDTH-1:0] data_i;
    logic [RX_DATA_WIDTH-1:0] data_q;
  } rx_sample_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HOLD  = 1'b1
  } out_state_t;

  function automatic rx_idx_t rr_next(input rx_idx_t idx, input int unsigned num);
    if (32'(idx) + 32'd1 >= num) begin
      return '0;
    end
    return idx + rx_idx_t'(1);
  endfunction

endpackage

// File: rtl/rx_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last granted index.
module rx_rr_arbiter
  import rx_arb_pkg::*;
#(
  parameter int unsigned NUM_RX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_RX-1:0] request,
  input  logic              advance,
  output logic [NUM_RX-1:0] grant,
  output rx_idx_t           grant_idx,
  output logic              any_grant
);

  rx_idx_t              last_grant;
  rx_idx_t              cand;
  logic [RX_MAX_CH-1:0] req_ext;

  // Widened so a fixed-width index can address the request vector for any NUM_RX.
  assign req_ext = RX_MAX_CH'(request);

  always_comb begin
    cand      = last_grant;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int unsigned i = 0; i < NUM_RX; i++) begin
      cand = rr_next(cand, NUM_RX);
      if (!any_grant && req_ext[cand]) begin
        any_grant = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int unsigned k = 0; k < NUM_RX; k++) begin
      grant[k] = any_grant && (grant_idx == rx_idx_t'(k));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= rx_idx_t'(NUM_RX - 1);
    end else if (advance && any_grant) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/rx_stream_arbiter.sv
// Buffers one I/Q sample per receiver channel and serialises them round-robin
// onto a single valid/ready stream, flagging per-channel overruns.
module rx_stream_arbiter
  import rx_arb_pkg::*;
#(
  parameter int unsigned NUM_RX     = 4,
  parameter int unsigned DATA_WIDTH = RX_DATA_WIDTH,
  parameter int unsigned CH_WIDTH   = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_RX-1:0]            rx_strobe,
  input  logic [NUM_RX*DATA_WIDTH-1:0] rx_data_I,
  input  logic [NUM_RX*DATA_WIDTH-1:0] rx_data_Q,
  input  logic [NUM_RX-1:0]            chan_enable,
  input  logic [NUM_RX-1:0]            ovf_clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH_WIDTH-1:0]          out_chan,
  output logic [DATA_WIDTH-1:0]        out_data_I,
  output logic [DATA_WIDTH-1:0]        out_data_Q,
  output logic [NUM_RX-1:0]            overflow
);

  logic [DATA_WIDTH-1:0] slot_i [NUM_RX];
  logic [DATA_WIDTH-1:0] slot_q [NUM_RX];
  logic [NUM_RX-1:0]     full;
  logic [NUM_RX-1:0]     capture;
  logic [NUM_RX-1:0]     drain;
  logic [NUM_RX-1:0]     grant;
  rx_idx_t               grant_idx;
  logic                  any_grant;
  logic                  load_en;
  logic [DATA_WIDTH-1:0] sel_i;
  logic [DATA_WIDTH-1:0] sel_q;
  out_state_t            state;

  assign load_en   = (state == OUT_EMPTY) || out_ready;
  assign capture   = rx_strobe & chan_enable;
  assign drain     = grant & {NUM_RX{load_en}};
  assign out_valid = (state == OUT_HOLD);

  rx_rr_arbiter #(
    .NUM_RX(NUM_RX)
  ) u_arb (
    .clock    (clock),
    .reset    (reset),
    .request  (full),
    .advance  (load_en),
    .grant    (grant),
    .grant_idx(grant_idx),
    .any_grant(any_grant)
  );

  // One-hot AND-OR select of the granted slot.
  always_comb begin
    sel_i = '0;
    sel_q = '0;
    for (int unsigned k = 0; k < NUM_RX; k++) begin
      if (grant[k]) begin
        sel_i = sel_i | slot_i[k];
        sel_q = sel_q | slot_q[k];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full     <= '0;
      overflow <= '0;
      for (int unsigned k = 0; k < NUM_RX; k++) begin
        slot_i[k] <= '0;
        slot_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_RX; k++) begin
        // A slot drained this cycle can accept a new sample without overrun.
        if (capture[k] && (!full[k] || drain[k])) begin
          slot_i[k] <= rx_data_I[k*DATA_WIDTH +: DATA_WIDTH];
          slot_q[k] <= rx_data_Q[k*DATA_WIDTH +: DATA_WIDTH];
          full[k]   <= 1'b1;
        end else if (drain[k]) begin
          full[k] <= 1'b0;
        end

        if (capture[k] && full[k] && !drain[k]) begin
          overflow[k] <= 1'b1;
        end else if (ovf_clear[k]) begin
          overflow[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= OUT_EMPTY;
      out_chan   <= '0;
      out_data_I <= '0;
      out_data_Q <= '0;
    end else if (load_en) begin
      if (any_grant) begin
        state      <= OUT_HOLD;
        out_chan   <= CH_WIDTH'(grant_idx);
        out_data_I <= sel_i;
        out_data_Q <= sel_q;
      end else begin
        state <= OUT_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// Self-checking bench for rx_stream_arbiter: latency vector table plus
// hand-written overrun, recapture, enable and reset sequences.
module tb_rx_stream_arbiter;
  import rx_arb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 24;
  localparam int unsigned CW = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      rx_strobe;
  logic [N*DW-1:0]   rx_data_I;
  logic [N*DW-1:0]   rx_data_Q;
  logic [N-1:0]      chan_enable;
  logic [N-1:0]      ovf_clear;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     out_chan;
  logic [DW-1:0]     out_data_I;
  logic [DW-1:0]     out_data_Q;
  logic [N-1:0]      overflow;

  rx_stream_arbiter #(
    .NUM_RX    (N),
    .DATA_WIDTH(DW),
    .CH_WIDTH  (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_strobe  (rx_strobe),
    .rx_data_I  (rx_data_I),
    .rx_data_Q  (rx_data_Q),
    .chan_enable(chan_enable),
    .ovf_clear  (ovf_clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_chan   (out_chan),
    .out_data_I (out_data_I),
    .out_data_Q (out_data_Q),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  rx_sample_t  sb[$];
  rx_sample_t  mon_exp;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    int unsigned ch;
    logic [DW-1:0] di;
    logic [DW-1:0] dq;
  } tv_t;

  tv_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load(input int unsigned ch, input logic [DW-1:0] di, input logic [DW-1:0] dq,
                      input bit push);
    rx_data_I[ch*DW +: DW] = di;
    rx_data_Q[ch*DW +: DW] = dq;
    rx_strobe[ch] = 1'b1;
    if (push) sb.push_back('{chan: rx_idx_t'(ch), data_i: di, data_q: dq});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    rx_strobe = '0;
    ovf_clear = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    reset     = 1'b1;
    rx_strobe = '0;
    ovf_clear = '0;
    step();
    reset = 1'b0;
    sb.delete();
  endtask

  // Transfers complete on the next rising edge; observe them mid-cycle.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got chan %0d I %0h, expected no output", out_chan, out_data_I);
      end else begin
        mon_exp = sb.pop_front();
        check("out_chan", 64'(out_chan), 64'(mon_exp.chan));
        check("out_data_I", 64'(out_data_I), 64'(mon_exp.data_i));
        check("out_data_Q", 64'(out_data_Q), 64'(mon_exp.data_q));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{ch: 2, di: 24'h123456, dq: 24'hFEDCBA};
    vecs[1] = '{ch: 0, di: 24'h000000, dq: 24'hFFFFFF};
    vecs[2] = '{ch: 3, di: 24'h800000, dq: 24'h7FFFFF};
    vecs[3] = '{ch: 1, di: 24'hA5A5A5, dq: 24'h5A5A5A};

    reset       = 1'b1;
    rx_strobe   = '0;
    rx_data_I   = '0;
    rx_data_Q   = '0;
    chan_enable = '1;
    ovf_clear   = '0;
    out_ready   = 1'b1;
    step();
    step();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_chan", 64'(out_chan), 64'd0);
    check("rst_data_I", 64'(out_data_I), 64'd0);
    check("rst_data_Q", 64'(out_data_Q), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    reset = 1'b0;

    // Single-strobe latency table: valid 2 edges after the strobe, for one cycle.
    for (int unsigned v = 0; v < 4; v++) begin
      load(vecs[v].ch, vecs[v].di, vecs[v].dq, 1'b1);
      tick();
      check("lat_e0_valid", 64'(out_valid), 64'd0);
      step();
      check("lat_e1_valid", 64'(out_valid), 64'd1);
      step();
      check("lat_single_cycle", 64'(out_valid), 64'd0);
      check("lat_overflow", 64'(overflow), 64'd0);
    end
    check("table_sb_empty", 64'(sb.size()), 64'd0);

    // Burst on all channels, twice: rotation 0..3 then again from 0.
    reset_dut();
    for (int unsigned b = 0; b < 2; b++) begin
      for (int unsigned c = 0; c < N; c++) load(c, 24'h100000 + 24'(b*16 + c), 24'h200000 + 24'(c), 1'b1);
      tick();
      for (int unsigned c = 0; c < N; c++) begin
        step();
        check("burst_valid", 64'(out_valid), 64'd1);
        check("burst_chan", 64'(out_chan), 64'(c));
      end
      step();
      check("burst_idle", 64'(out_valid), 64'd0);
    end
    check("burst_sb_empty", 64'(sb.size()), 64'd0);

    // Overrun while the output is stalled; dropped sample never appears.
    reset_dut();
    out_ready = 1'b0;
    load(0, 24'h0000AA, 24'h0000BB, 1'b1);
    tick();
    step();
    load(1, 24'hAAAAAA, 24'h111111, 1'b1);
    tick();
    load(1, 24'hBBBBBB, 24'h222222, 1'b0);
    tick();
    check("ovr_flag", 64'(overflow), 64'h2);
    check("ovr_hold_valid", 64'(out_valid), 64'd1);
    check("ovr_hold_chan", 64'(out_chan), 64'd0);
    step();
    check("ovr_hold_data", 64'(out_data_I), 64'h0000AA);
    out_ready = 1'b1;
    step();
    check("ovr_a_chan", 64'(out_chan), 64'd1);
    step();
    check("ovr_a_only", 64'(out_valid), 64'd0);
    check("ovr_sticky", 64'(overflow), 64'h2);
    ovf_clear[1] = 1'b1;
    tick();
    check("ovr_cleared", 64'(overflow), 64'd0);

    // Set and clear in the same cycle: set wins.
    out_ready = 1'b0;
    load(0, 24'h0000CC, 24'h0000DD, 1'b1);
    tick();
    load(1, 24'hCCCCCC, 24'h333333, 1'b1);
    tick();
    load(1, 24'hDDDDDD, 24'h444444, 1'b0);
    ovf_clear[1] = 1'b1;
    tick();
    check("ovr_set_wins", 64'(overflow), 64'h2);
    ovf_clear[1] = 1'b1;
    tick();
    check("ovr_clear2", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    repeat (4) step();
    check("ovr_sb_empty", 64'(sb.size()), 64'd0);

    // Recapture into a slot that drains on the same edge.
    reset_dut();
    load(0, 24'h000001, 24'hF00001, 1'b1);
    tick();
    load(0, 24'h000002, 24'hF00002, 1'b1);
    tick();
    check("recap_valid1", 64'(out_valid), 64'd1);
    load(0, 24'h000003, 24'hF00003, 1'b1);
    tick();
    check("recap_valid2", 64'(out_valid), 64'd1);
    check("recap_no_ovf", 64'(overflow), 64'd0);
    step();
    check("recap_valid3", 64'(out_valid), 64'd1);
    step();
    check("recap_idle", 64'(out_valid), 64'd0);
    check("recap_sb_empty", 64'(sb.size()), 64'd0);

    // Channel 2 disabled: ignored strobes, no overflow, others in order.
    reset_dut();
    chan_enable = 4'b1011;
    for (int unsigned c = 0; c < N; c++) load(c, 24'h300000 + 24'(c), 24'h400000 + 24'(c), c != 2);
    tick();
    for (int unsigned c = 0; c < N; c++) begin
      if (c != 2) begin
        step();
        check("en_valid", 64'(out_valid), 64'd1);
        check("en_chan", 64'(out_chan), 64'(c));
      end
    end
    load(2, 24'h555555, 24'h555555, 1'b0);
    tick();
    load(2, 24'h666666, 24'h666666, 1'b0);
    tick();
    step();
    check("en_idle", 64'(out_valid), 64'd0);
    check("en_no_ovf", 64'(overflow), 64'd0);

    // A full slot still drains after its channel is disabled.
    reset_dut();
    chan_enable = '1;
    out_ready = 1'b0;
    load(0, 24'h700000, 24'h700001, 1'b1);
    load(2, 24'h720000, 24'h720001, 1'b1);
    tick();
    step();
    chan_enable[2] = 1'b0;
    load(2, 24'h7FFFFF, 24'h7FFFFF, 1'b0);
    tick();
    check("dis_no_ovf", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    step();
    check("dis_drain_chan", 64'(out_chan), 64'd2);
    check("dis_drain_valid", 64'(out_valid), 64'd1);
    step();
    check("dis_idle", 64'(out_valid), 64'd0);
    chan_enable = '1;
    check("dis_sb_empty", 64'(sb.size()), 64'd0);

    // Reset mid-transfer discards everything; first grant afterwards is channel 0.
    reset_dut();
    out_ready = 1'b0;
    for (int unsigned c = 0; c < N; c++) load(c, 24'h900000 + 24'(c), 24'h910000 + 24'(c), 1'b1);
    tick();
    step();
    check("mid_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    check("async_valid", 64'(out_valid), 64'd0);
    check("async_data", 64'(out_data_I), 64'd0);
    sb.delete();
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int unsigned c = 0; c < 4; c++) begin
      step();
      check("no_stale", 64'(out_valid), 64'd0);
    end
    load(0, 24'hABC000, 24'hABC001, 1'b1);
    load(1, 24'hABC100, 24'hABC101, 1'b1);
    tick();
    step();
    check("post_rst_chan0", 64'(out_chan), 64'd0);
    step();
    check("post_rst_chan1", 64'(out_chan), 64'd1);
    step();
    check("post_rst_idle", 64'(out_valid), 64'd0);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
